// File: rtl/la_ram_loader_pkg.sv
// Shared encodings for the LA-driven RAM loader: firmware commands and FSM states.
package la_ram_loader_pkg;

  localparam int unsigned CMD_W = 2;

  typedef enum logic [CMD_W-1:0] {
    CMD_HALT  = 2'b00,
    CMD_WRITE = 2'b01,
    CMD_READ  = 2'b10,
    CMD_RUN   = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    ST_HALT   = 3'd0,
    ST_WRITE  = 3'd1,
    ST_READ   = 3'd2,
    ST_RDWAIT = 3'd3,
    ST_RUN    = 3'd4
  } state_e;

endpackage

// File: rtl/la_ram_loader_if.sv
// Logic-analyzer request/ack bus between management firmware (master) and the loader (slave).
interface la_ram_loader_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
);
  import la_ram_loader_pkg::*;

  logic              la_req;
  logic [CMD_W-1:0]  la_cmd;
  logic [ADDR_W-1:0] la_addr;
  logic [DATA_W-1:0] la_wdata;
  logic              la_ack;
  logic [DATA_W-1:0] la_rdata;
  logic              la_err;
  logic              la_running;

  modport master (
    output la_req, la_cmd, la_addr, la_wdata,
    input  la_ack, la_rdata, la_err, la_running
  );

  modport slave (
    input  la_req, la_cmd, la_addr, la_wdata,
    output la_ack, la_rdata, la_err, la_running
  );
endinterface

// File: rtl/la_ram_loader_req_sync.sv
// Two-flop synchroniser for the firmware request toggle, flagging a request not yet acknowledged.
module la_req_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic la_req,
  input  logic req_seen,
  input  logic clear,
  output logic pending,
  output logic req_sync
);

  logic s1;
  logic s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= la_req;
      s2 <= s1;
    end
  end

  // clear masks the request while the loader is mid-operation
  assign req_sync = s2;
  assign pending  = (s2 != req_seen) && !clear;

endmodule

// File: rtl/la_ram_loader.sv
// Loads the CPU RAM from LA probes while holding the CPU in reset, then hands the RAM to the CPU on RUN.
module la_ram_loader
  import la_ram_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              wb_clk_i,
  input  logic              resetb,
  la_ram_loader_if.slave    la,
  output logic [ADDR_W:0]   wr_count,
  output logic [DATA_W-1:0] checksum,
  output logic              cpu_rst_n,
  input  logic              cpu_ram_en,
  input  logic              cpu_ram_we,
  input  logic [ADDR_W-1:0] cpu_ram_addr,
  input  logic [DATA_W-1:0] cpu_ram_wdata,
  output logic [DATA_W-1:0] cpu_ram_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  state_e            state;
  logic              req_seen;
  logic              req_sync;
  logic              pending;
  logic              busy;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;
  logic              ack_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              running_q;
  logic              cpu_rst_n_q;
  logic [CNT_W-1:0]  wr_count_q;
  logic [DATA_W-1:0] checksum_q;

  assign busy = (state == ST_WRITE) || (state == ST_READ) || (state == ST_RDWAIT);

  la_req_sync u_req_sync (
    .clk      (wb_clk_i),
    .rst_n    (resetb),
    .la_req   (la.la_req),
    .req_seen (req_seen),
    .clear    (busy),
    .pending  (pending),
    .req_sync (req_sync)
  );

  // Loader FSM; every acted-on request finishes with one ack toggle and req_seen catching up
  always_ff @(posedge wb_clk_i or negedge resetb) begin
    if (!resetb) begin
      state       <= ST_HALT;
      req_seen    <= 1'b0;
      cap_addr    <= '0;
      cap_wdata   <= '0;
      ack_q       <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      running_q   <= 1'b0;
      cpu_rst_n_q <= 1'b0;
      wr_count_q  <= '0;
      checksum_q  <= '0;
    end else begin
      case (state)
        ST_HALT: begin
          if (pending) begin
            cap_addr  <= la.la_addr;
            cap_wdata <= la.la_wdata;
            case (cmd_e'(la.la_cmd))
              CMD_WRITE: state <= ST_WRITE;
              CMD_READ:  state <= ST_READ;
              CMD_RUN: begin
                ack_q       <= ~ack_q;
                req_seen    <= req_sync;
                cpu_rst_n_q <= 1'b1;
                running_q   <= 1'b1;
                state       <= ST_RUN;
              end
              default: begin
                ack_q    <= ~ack_q;
                req_seen <= req_sync;
              end
            endcase
          end
        end
        ST_WRITE: begin
          ack_q      <= ~ack_q;
          req_seen   <= req_sync;
          checksum_q <= checksum_q ^ cap_wdata;
          if (wr_count_q != {CNT_W{1'b1}}) wr_count_q <= wr_count_q + CNT_W'(1);
          state      <= ST_HALT;
        end
        ST_READ: state <= ST_RDWAIT;
        ST_RDWAIT: begin
          rdata_q  <= ram_rdata;
          ack_q    <= ~ack_q;
          req_seen <= req_sync;
          state    <= ST_HALT;
        end
        ST_RUN: begin
          if (pending) begin
            ack_q    <= ~ack_q;
            req_seen <= req_sync;
            case (cmd_e'(la.la_cmd))
              CMD_HALT: begin
                cpu_rst_n_q <= 1'b0;
                running_q   <= 1'b0;
                state       <= ST_HALT;
              end
              CMD_WRITE, CMD_READ: err_q <= 1'b1;
              default: ;
            endcase
          end
        end
        default: state <= ST_HALT;
      endcase
    end
  end

  // RAM port owner: CPU in RUN, loader otherwise
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (state)
      ST_RUN: begin
        ram_en    = cpu_ram_en;
        ram_we    = cpu_ram_we;
        ram_addr  = cpu_ram_addr;
        ram_wdata = cpu_ram_wdata;
      end
      ST_WRITE: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = cap_addr;
        ram_wdata = cap_wdata;
      end
      ST_READ: begin
        ram_en   = 1'b1;
        ram_addr = cap_addr;
      end
      default: ;
    endcase
  end

  assign cpu_ram_rdata = ram_rdata;
  assign la.la_ack     = ack_q;
  assign la.la_rdata   = rdata_q;
  assign la.la_err     = err_q;
  assign la.la_running = running_q;
  assign cpu_rst_n     = cpu_rst_n_q;
  assign wr_count      = wr_count_q;
  assign checksum      = checksum_q;

endmodule
